reg_read_hazard_ctrl: RTL and testbench

- Decode-stage register-read controller for the 5-stage MIPS pipeline.
- Selects the read-port A/B register addresses for the instruction in ID (normal, shift-swapped, syscall-fixed).
- Tracks in-flight destination registers through a parametrised shift pipeline and produces the stall and forwarding selects for the operands.
- Sits between IF/ID and the register file / ID-EX operand muxes.

---
 rtl/reg_read_hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_reg_read_hazard_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_read_hazard_ctrl.sv
// Decode-stage register-read controller: read-port address select, in-flight destination tracking, stall and forwarding selects.
// Define RA_HAZ_FORWARD_EN for forwarding with load-use stall only; otherwise any in-flight hazard stalls and fwd_a/fwd_b stay 0.
module reg_read_hazard_ctrl #(
  parameter int DEPTH  = 3,
  parameter int REG_AW = 5,
  parameter int FW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instruction,
  input  logic              id_valid,
  input  logic              flush,
  output logic [REG_AW-1:0] ra_addr,
  output logic [REG_AW-1:0] rb_addr,
  output logic [1:0]        r_mode,
  output logic              ra_used,
  output logic              rb_used,
  output logic              stall,
  output logic [FW-1:0]     fwd_a,
  output logic [FW-1:0]     fwd_b
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;

  assign op    = instruction[31:26];
  assign rs    = instruction[25:21];
  assign rt    = instruction[20:16];
  assign rd    = instruction[15:11];
  assign funct = instruction[5:0];

  logic r_type;
  logic is_shift;
  logic is_var_shift;
  logic is_syscall;
  logic is_jr;

  assign r_type       = (op == 6'b000000);
  // Shift functs are 000xxx minus 001 and 101; bit 2 marks the variable forms.
  assign is_shift     = (funct[5:3] == 3'b000) && (funct[1:0] != 2'b01);
  assign is_var_shift = is_shift && funct[2];
  assign is_syscall   = (funct == 6'b001100);
  assign is_jr        = (funct == 6'b001000);

  logic [REG_AW-1:0] dst_id;
  logic              load_id;

  always_comb begin
    ra_addr = REG_AW'(rs);
    rb_addr = REG_AW'(rt);
    r_mode  = 2'b00;
    ra_used = 1'b1;
    rb_used = 1'b0;
    dst_id  = '0;
    load_id = 1'b0;
    if (r_type) begin
      if (is_shift) begin
        r_mode  = 2'b11;
        ra_addr = REG_AW'(rt);
        rb_addr = REG_AW'(rs);
        rb_used = is_var_shift;
        dst_id  = REG_AW'(rd);
      end else if (is_syscall) begin
        r_mode  = 2'b01;
        ra_addr = REG_AW'(2);
        rb_addr = REG_AW'(4);
        rb_used = 1'b1;
      end else begin
        rb_used = !is_jr;
        if (!is_jr) dst_id = REG_AW'(rd);
      end
    end else begin
      ra_used = !((op == 6'b000010) || (op == 6'b000011) || (op == 6'b001111));
      rb_used = (op[5:3] == 3'b101) || (op[5:1] == 5'b00010);
      if (op[5:3] == 3'b001) begin
        dst_id = REG_AW'(rt);
      end else if (op[5:3] == 3'b100) begin
        dst_id  = REG_AW'(rt);
        load_id = 1'b1;
      end else if (op == 6'b000011) begin
        dst_id = REG_AW'(31);
      end
    end
  end

  // Entry k holds the instruction now in stage k (1 = EX ... DEPTH = WB).
  logic [DEPTH:1]    valid_reg;
  logic [DEPTH:1]    load_reg;
  logic [REG_AW-1:0] dst_reg [1:DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= '0;
      load_reg  <= '0;
      for (int k = 1; k <= DEPTH; k++) dst_reg[k] <= '0;
    end else begin
      valid_reg[1] <= id_valid && !flush && !stall && (dst_id != '0);
      load_reg[1]  <= load_id;
      dst_reg[1]   <= dst_id;
      for (int k = 2; k <= DEPTH; k++) begin
        valid_reg[k] <= valid_reg[k-1];
        load_reg[k]  <= load_reg[k-1];
        dst_reg[k]   <= dst_reg[k-1];
      end
    end
  end

  logic [DEPTH:1] match_a;
  logic [DEPTH:1] match_b;

  generate
    for (genvar gi = 1; gi <= DEPTH; gi++) begin : g_match
      assign match_a[gi] = valid_reg[gi] && (dst_reg[gi] != '0) &&
                           (dst_reg[gi] == ra_addr) && ra_used;
      assign match_b[gi] = valid_reg[gi] && (dst_reg[gi] != '0) &&
                           (dst_reg[gi] == rb_addr) && rb_used;
    end
  endgenerate

`ifdef RA_HAZ_FORWARD_EN
  // Scan oldest to youngest so the youngest matching stage wins.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (match_a[k]) fwd_a = FW'(k);
      if (match_b[k]) fwd_b = FW'(k);
    end
  end

  assign stall = id_valid && !flush && load_reg[1] && (match_a[1] || match_b[1]);
`else
  assign fwd_a = '0;
  assign fwd_b = '0;
  assign stall = id_valid && !flush && ((|match_a) || (|match_b));
`endif

  logic unused_bits;
  assign unused_bits = ^{instruction[10:6], load_reg};

endmodule

// File: tb/tb_reg_read_hazard_ctrl.sv
// Scoreboard bench for reg_read_hazard_ctrl (DEPTH=3); expectations follow RA_HAZ_FORWARD_EN when defined.
module tb_reg_read_hazard_ctrl;
  localparam int DEPTH  = 3;
  localparam int REG_AW = 5;
  localparam int FW     = $clog2(DEPTH + 1);
`ifdef RA_HAZ_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       instruction = 32'h0;
  logic              id_valid = 1'b0;
  logic              flush = 1'b0;
  logic [REG_AW-1:0] ra_addr;
  logic [REG_AW-1:0] rb_addr;
  logic [1:0]        r_mode;
  logic              ra_used;
  logic              rb_used;
  logic              stall;
  logic [FW-1:0]     fwd_a;
  logic [FW-1:0]     fwd_b;

  always #5 clk = ~clk;

  reg_read_hazard_ctrl #(.DEPTH(DEPTH), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .id_valid(id_valid),
    .flush(flush), .ra_addr(ra_addr), .rb_addr(rb_addr), .r_mode(r_mode),
    .ra_used(ra_used), .rb_used(rb_used), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  typedef struct {
    string         name;
    logic [31:0]   ins;
    logic          v, f, rn;
    logic          st;
    logic [FW-1:0] fa, fb;
    logic          dc;
    logic          chk_dec;
    logic [4:0]    ra, rb;
    logic [1:0]    mode;
    logic          rau, rbu;
  } txn_t;

  txn_t sb[$];
  int checks = 0;
  int passed = 0;

  function automatic logic [31:0] rtype(int s, int t, int d, int sh, logic [5:0] fn);
    return {6'd0, 5'(s), 5'(t), 5'(d), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] itype(logic [5:0] o, int s, int t, int imm);
    return {o, 5'(s), 5'(t), 16'(imm)};
  endfunction

  // Hazard-only transaction; dc marks fwd as don't-care (stalled).
  function automatic txn_t V(string n, logic [31:0] ins, logic v, logic f, logic rn,
                             logic st, int fa, int fb, logic dc);
    txn_t t;
    t.name = n; t.ins = ins; t.v = v; t.f = f; t.rn = rn;
    t.st = st; t.fa = FW'(fa); t.fb = FW'(fb); t.dc = dc;
    t.chk_dec = 1'b0; t.ra = '0; t.rb = '0; t.mode = '0; t.rau = 1'b0; t.rbu = 1'b0;
    return t;
  endfunction

  function automatic txn_t D(string n, logic [31:0] ins, logic v, int ra, int rb,
                             logic [1:0] mode, logic rau, logic rbu);
    txn_t t;
    t = V(n, ins, v, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    t.chk_dec = 1'b1; t.ra = 5'(ra); t.rb = 5'(rb); t.mode = mode; t.rau = rau; t.rbu = rbu;
    return t;
  endfunction

  task automatic apply(input txn_t t);
    @(posedge clk);
    #1;
    instruction = t.ins;
    id_valid    = t.v;
    flush       = t.f;
    rst_n       = t.rn;
    sb.push_back(t);
  endtask

  logic [31:0] ADD_3_1_2, ADD_3_3_3, SUB_4_3_3, OR_7_3_0, LW_5_1, ADD_6_5_2, ADD_6_5_5;
  logic [31:0] SYSCALL, SLL_2_7_4, SRLV_3_5_6, SW_5_1, BEQ_1_2, LUI_4, JAL, JR_31;
  logic [31:0] ADDI_0_1_5, ADD_2_0_0, ADDU_2_31_0;

  task automatic bubbles(inout txn_t q[$]);
    repeat (3) q.push_back(V("bubble", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0));
  endtask

  task automatic test_reset();
    txn_t q[$];
    txn_t e;
    q.push_back(V("rst_add0", ADD_3_3_3, 1, 0, 0, 0, 0, 0, 0));
    q.push_back(V("rst_add1", ADD_3_3_3, 1, 0, 0, 0, 0, 0, 0));
    q.push_back(V("post_rst_add", ADD_3_1_2, 1, 0, 1, 0, 0, 0, 0));
    foreach (q[i]) begin
      apply(q[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({stall, fwd_a, fwd_b} !== {e.st, e.fa, e.fb})
        $display("FAIL %s: got stall=%0b fwd=%0d/%0d, want stall=%0b fwd=%0d/%0d",
                 e.name, stall, fwd_a, fwd_b, e.st, e.fa, e.fb);
      else passed++;
      $display("txn %s ins=%08h stall=%0b fwd_a=%0d fwd_b=%0d", e.name, e.ins, stall, fwd_a, fwd_b);
    end
  endtask

  task automatic test_back_to_back();
    txn_t q[$];
    txn_t e;
    bubbles(q);
    q.push_back(V("add3", ADD_3_1_2, 1, 0, 1, 0, 0, 0, 0));
    if (FWD) begin
      q.push_back(V("sub_dep", SUB_4_3_3, 1, 0, 1, 0, 1, 1, 0));
      q.push_back(V("or_dep2", OR_7_3_0, 1, 0, 1, 0, 2, 0, 0));
    end else begin
      repeat (3) q.push_back(V("sub_stall", SUB_4_3_3, 1, 0, 1, 1, 0, 0, 0));
      q.push_back(V("sub_go", SUB_4_3_3, 1, 0, 1, 0, 0, 0, 0));
      q.push_back(V("or_clear", OR_7_3_0, 1, 0, 1, 0, 0, 0, 0));
    end
    foreach (q[i]) begin
      apply(q[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({stall, fwd_a, fwd_b} !== {e.st, e.fa, e.fb})
        $display("FAIL %s: got stall=%0b fwd=%0d/%0d, want stall=%0b fwd=%0d/%0d",
                 e.name, stall, fwd_a, fwd_b, e.st, e.fa, e.fb);
      else passed++;
      $display("txn %s ins=%08h stall=%0b fwd_a=%0d fwd_b=%0d", e.name, e.ins, stall, fwd_a, fwd_b);
    end
  endtask

  task automatic test_load_use();
    txn_t q[$];
    txn_t e;
    bubbles(q);
    q.push_back(V("lw5", LW_5_1, 1, 0, 1, 0, 0, 0, 0));
    if (FWD) begin
      q.push_back(V("use_stall", ADD_6_5_2, 1, 0, 1, 1, 0, 0, 1));
      q.push_back(V("use_fwd", ADD_6_5_2, 1, 0, 1, 0, 2, 0, 0));
    end else begin
      repeat (3) q.push_back(V("use_stall", ADD_6_5_2, 1, 0, 1, 1, 0, 0, 0));
      q.push_back(V("use_go", ADD_6_5_2, 1, 0, 1, 0, 0, 0, 0));
    end
    foreach (q[i]) begin
      apply(q[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (e.dc ? (stall !== e.st) : ({stall, fwd_a, fwd_b} !== {e.st, e.fa, e.fb}))
        $display("FAIL %s: got stall=%0b fwd=%0d/%0d, want stall=%0b fwd=%0d/%0d",
                 e.name, stall, fwd_a, fwd_b, e.st, e.fa, e.fb);
      else passed++;
      $display("txn %s ins=%08h stall=%0b fwd_a=%0d fwd_b=%0d", e.name, e.ins, stall, fwd_a, fwd_b);
    end
  endtask

  task automatic test_decode();
    txn_t q[$];
    txn_t e;
    bubbles(q);
    q.push_back(D("syscall", SYSCALL, 1, 2, 4, 2'b01, 1, 1));
    q.push_back(D("add", ADD_3_1_2, 0, 1, 2, 2'b00, 1, 1));
    q.push_back(D("srlv", SRLV_3_5_6, 0, 5, 6, 2'b11, 1, 1));
    q.push_back(D("lw", LW_5_1, 0, 1, 5, 2'b00, 1, 0));
    q.push_back(D("sw", SW_5_1, 0, 1, 5, 2'b00, 1, 1));
    q.push_back(D("beq", BEQ_1_2, 0, 1, 2, 2'b00, 1, 1));
    q.push_back(D("lui", LUI_4, 0, 0, 4, 2'b00, 0, 0));
    q.push_back(D("jal", JAL, 0, 0, 0, 2'b00, 0, 0));
    q.push_back(D("jr", JR_31, 0, 31, 0, 2'b00, 1, 0));
    q.push_back(D("sll", SLL_2_7_4, 1, 7, 0, 2'b11, 1, 0));
    foreach (q[i]) begin
      apply(q[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({stall, fwd_a, fwd_b} !== {e.st, e.fa, e.fb})
        $display("FAIL %s_hz: got stall=%0b fwd=%0d/%0d, want stall=%0b fwd=%0d/%0d",
                 e.name, stall, fwd_a, fwd_b, e.st, e.fa, e.fb);
      else passed++;
      if (e.chk_dec) begin
        checks++;
        if ({ra_addr, rb_addr, r_mode, ra_used, rb_used} !== {e.ra, e.rb, e.mode, e.rau, e.rbu})
          $display("FAIL %s_dec: got ra=%0d rb=%0d mode=%b used=%b%b, want ra=%0d rb=%0d mode=%b used=%b%b",
                   e.name, ra_addr, rb_addr, r_mode, ra_used, rb_used,
                   e.ra, e.rb, e.mode, e.rau, e.rbu);
        else passed++;
      end
      $display("txn %s ins=%08h ra=%0d rb=%0d mode=%b used=%b%b stall=%0b", e.name, e.ins,
               ra_addr, rb_addr, r_mode, ra_used, rb_used, stall);
    end
  endtask

  task automatic test_zero_jal();
    txn_t q[$];
    txn_t e;
    bubbles(q);
    q.push_back(V("addi_r0", ADDI_0_1_5, 1, 0, 1, 0, 0, 0, 0));
    q.push_back(V("add_r0r0", ADD_2_0_0, 1, 0, 1, 0, 0, 0, 0));
    q.push_back(V("jal", JAL, 1, 0, 1, 0, 0, 0, 0));
    if (FWD) begin
      q.push_back(V("addu_r31", ADDU_2_31_0, 1, 0, 1, 0, 1, 0, 0));
    end else begin
      repeat (3) q.push_back(V("addu_stall", ADDU_2_31_0, 1, 0, 1, 1, 0, 0, 0));
      q.push_back(V("addu_go", ADDU_2_31_0, 1, 0, 1, 0, 0, 0, 0));
    end
    foreach (q[i]) begin
      apply(q[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({stall, fwd_a, fwd_b} !== {e.st, e.fa, e.fb})
        $display("FAIL %s: got stall=%0b fwd=%0d/%0d, want stall=%0b fwd=%0d/%0d",
                 e.name, stall, fwd_a, fwd_b, e.st, e.fa, e.fb);
      else passed++;
      $display("txn %s ins=%08h stall=%0b fwd_a=%0d fwd_b=%0d", e.name, e.ins, stall, fwd_a, fwd_b);
    end
  endtask

  task automatic test_flush();
    txn_t q[$];
    txn_t e;
    bubbles(q);
    q.push_back(V("lw5", LW_5_1, 1, 0, 1, 0, 0, 0, 0));
    if (FWD) begin
      q.push_back(V("flushed_use", ADD_6_5_5, 1, 1, 1, 0, 1, 1, 0));
      q.push_back(V("after_flush", ADD_6_5_5, 1, 0, 1, 0, 2, 2, 0));
    end else begin
      q.push_back(V("flushed_use", ADD_6_5_5, 1, 1, 1, 0, 0, 0, 0));
      repeat (2) q.push_back(V("after_flush", ADD_6_5_5, 1, 0, 1, 1, 0, 0, 0));
      q.push_back(V("after_go", ADD_6_5_5, 1, 0, 1, 0, 0, 0, 0));
    end
    foreach (q[i]) begin
      apply(q[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({stall, fwd_a, fwd_b} !== {e.st, e.fa, e.fb})
        $display("FAIL %s: got stall=%0b fwd=%0d/%0d, want stall=%0b fwd=%0d/%0d",
                 e.name, stall, fwd_a, fwd_b, e.st, e.fa, e.fb);
      else passed++;
      $display("txn %s ins=%08h stall=%0b fwd_a=%0d fwd_b=%0d", e.name, e.ins, stall, fwd_a, fwd_b);
    end
  endtask

  task automatic test_reset_mid_stall();
    txn_t q[$];
    txn_t e;
    bubbles(q);
    q.push_back(V("lw5", LW_5_1, 1, 0, 1, 0, 0, 0, 0));
    q.push_back(V("stall_rst", ADD_6_5_2, 1, 0, 0, 1, 0, 0, FWD));
    q.push_back(V("post_rst", ADD_6_5_2, 1, 0, 1, 0, 0, 0, 0));
    foreach (q[i]) begin
      apply(q[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (e.dc ? (stall !== e.st) : ({stall, fwd_a, fwd_b} !== {e.st, e.fa, e.fb}))
        $display("FAIL %s: got stall=%0b fwd=%0d/%0d, want stall=%0b fwd=%0d/%0d",
                 e.name, stall, fwd_a, fwd_b, e.st, e.fa, e.fb);
      else passed++;
      $display("txn %s ins=%08h stall=%0b fwd_a=%0d fwd_b=%0d", e.name, e.ins, stall, fwd_a, fwd_b);
    end
  endtask

  initial begin
    ADD_3_1_2   = rtype(1, 2, 3, 0, 6'h20);
    ADD_3_3_3   = rtype(3, 3, 3, 0, 6'h20);
    SUB_4_3_3   = rtype(3, 3, 4, 0, 6'h22);
    OR_7_3_0    = rtype(3, 0, 7, 0, 6'h25);
    LW_5_1      = itype(6'b100011, 1, 5, 0);
    ADD_6_5_2   = rtype(5, 2, 6, 0, 6'h20);
    ADD_6_5_5   = rtype(5, 5, 6, 0, 6'h20);
    SYSCALL     = rtype(0, 0, 0, 0, 6'h0C);
    SLL_2_7_4   = rtype(0, 7, 2, 4, 6'h00);
    SRLV_3_5_6  = rtype(6, 5, 3, 0, 6'h06);
    SW_5_1      = itype(6'b101011, 1, 5, 4);
    BEQ_1_2     = itype(6'b000100, 1, 2, 3);
    LUI_4       = itype(6'b001111, 0, 4, 16'h1234);
    JAL         = {6'b000011, 26'h40};
    JR_31       = rtype(31, 0, 0, 0, 6'h08);
    ADDI_0_1_5  = itype(6'b001000, 1, 0, 5);
    ADD_2_0_0   = rtype(0, 0, 2, 0, 6'h20);
    ADDU_2_31_0 = rtype(31, 0, 2, 0, 6'h21);

    rst_n = 1'b0;
    test_reset();
    test_back_to_back();
    test_load_use();
    test_decode();
    test_zero_jal();
    test_flush();
    test_reset_mid_stall();

    checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d left, want 0", sb.size());
    else passed++;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule
